// File: rtl/led_pattern_seq_if.sv
// led_pattern_seq_if: pattern/dimmer control and LED drive bundle.
// master: drives mode, brightness; slave: drives tick, led.
interface led_pattern_seq_if #(
    parameter int PWM_BITS = 4
);
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] brightness;
    logic                tick;
    logic [5:0]          led;

    modport master (
        output mode,
        output brightness,
        input  tick,
        input  led
    );

    modport slave (
        input  mode,
        input  brightness,
        output tick,
        output led
    );
endinterface

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: step-pattern generator with PWM dimming for six
// active-low LEDs. Ports: clk, rst (sync, active-high), io.slave
// (mode, brightness in; tick, led out). Macro LED_PWM_EN enables
// the PWM dimmer; without it brightness is ignored and LEDs run
// at full on.
module led_pattern_seq #(
    parameter int CLK_HZ   = 27_000_000,
    parameter int STEP_HZ  = 4,
    parameter int PWM_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    led_pattern_seq_if.slave io
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        M_COUNT = 2'b00,
        M_SCAN  = 2'b01,
        M_BLINK = 2'b10,
        M_HOLD  = 2'b11
    } mode_t;

    logic [PW-1:0] pcnt;
    logic          tick_q;
    logic [5:0]    pat;
    mode_t         mode_q;
    mode_t         mode_in;
    logic [2:0]    pos;
    logic          dir;
    logic [2:0]    pos_nxt;
    logic          dir_nxt;
    logic [5:0]    led_q;
    logic          on;

    assign mode_in = mode_t'(io.mode);

    // Bounce walk: dir 0 = up, 1 = down; ends are visited once.
    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        if (!dir) begin
            if (pos == 3'd5) begin
                pos_nxt = 3'd4;
                dir_nxt = 1'b1;
            end else begin
                pos_nxt = pos + 3'd1;
            end
        end else begin
            if (pos == 3'd0) begin
                pos_nxt = 3'd1;
                dir_nxt = 1'b0;
            end else begin
                pos_nxt = pos - 3'd1;
            end
        end
    end

    // tick is registered: raised one cycle ahead so it is high
    // exactly while pcnt sits at DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt   <= '0;
            tick_q <= 1'b0;
            pat    <= '0;
            mode_q <= M_COUNT;
            pos    <= 3'd0;
            dir    <= 1'b0;
        end else begin
            if (pcnt == PW'(DIV - 1)) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            tick_q <= (pcnt == PW'(DIV - 2));
            if (tick_q) begin
                if (mode_in != mode_q) begin
                    mode_q <= mode_in;
                    unique case (mode_in)
                        M_COUNT: pat <= '0;
                        M_SCAN: begin
                            pat <= 6'b000001;
                            pos <= 3'd0;
                            dir <= 1'b0;
                        end
                        M_BLINK: pat <= '1;
                        M_HOLD:  pat <= pat;
                    endcase
                end else begin
                    unique case (mode_q)
                        M_COUNT: pat <= pat + 6'd1;
                        M_SCAN: begin
                            pat <= 6'd1 << pos_nxt;
                            pos <= pos_nxt;
                            dir <= dir_nxt;
                        end
                        M_BLINK: pat <= ~pat;
                        M_HOLD:  pat <= pat;
                    endcase
                end
            end
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] wcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
        end
    end

    // All-ones brightness would otherwise miss the top count.
    assign on = (&io.brightness) | (wcnt < io.brightness);
`else
    wire unused_brightness = ^io.brightness;

    assign on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '1;
        end else begin
            led_q <= ~(pat & {6{on}});
        end
    end

    assign io.tick = tick_q;
    assign io.led  = led_q;
endmodule
